// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned/two's-complement subtractor. A request on i_start while
// idle captures both operands; the difference is then produced one bit per
// clock, LSB first, through a single full-subtractor cell and a borrow flop.
// After WIDTH processing cycles the result and flags are published together
// with a one-cycle o_done pulse, and the block is ready again.
//
// Parameters
//   WIDTH       operand / result width in bits (2..32)
//
// Ports
//   i_clk       clock, rising-edge active
//   i_reset     synchronous, active-high reset
//   i_start     begin a subtraction (only honoured while idle)
//   i_a         minuend, captured on the accepting edge
//   i_b         subtrahend, captured on the accepting edge
//   o_busy      high while an operation is in progress
//   o_done      one-cycle pulse when the outputs below are updated
//   o_diff      (i_a - i_b) mod 2^WIDTH
//   o_borrow    final borrow out (i_a < i_b, unsigned)
//   o_zero      o_diff == 0
//   o_overflow  signed two's-complement overflow of i_a - i_b
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_zero,
  output logic             o_overflow
);

  // The counter must be able to hold WIDTH itself so its width is derived
  // from WIDTH+1; only values 0..WIDTH-1 are actually used while running.
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow_q;
  logic             a_msb;
  logic             b_msb;

  logic             accept;
  logic             last_step;
  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] diff_shifted;

  // Full-subtractor cell working on the current LSBs of the operand shifters.
  assign diff_bit    = a_sr[0] ^ b_sr[0] ^ borrow_q;
  assign borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow_q);

  // Result register as it will look after this edge's shift. On the final
  // step this is the complete difference, so the published outputs can be
  // loaded from it on the same edge instead of one cycle later.
  assign diff_shifted = {diff_bit, res_sr[WIDTH-1:1]};

  assign accept    = (state == IDLE) && i_start;
  assign last_step = (state == RUN) && (bit_cnt == LAST_BIT);

  assign o_busy = (state == RUN);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (bit_cnt == LAST_BIT) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand shifters, borrow flop and bit counter. Operands are only written
  // on the accepting edge, so later activity on i_a/i_b or a repeated
  // i_start during RUN cannot disturb an operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      bit_cnt  <= '0;
    end else if (accept) begin
      a_sr     <= i_a;
      b_sr     <= i_b;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      a_msb    <= i_a[WIDTH-1];
      b_msb    <= i_b[WIDTH-1];
      bit_cnt  <= '0;
    end else if (state == RUN) begin
      a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr   <= diff_shifted;
      borrow_q <= borrow_next;
      if (last_step) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Published result and flags. They only move on a completion edge (or
  // reset) so a consumer may sample them at any time after o_done.
  // The last diff_bit computed is the result MSB, used for overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_done     <= 1'b0;
      o_diff     <= '0;
      o_borrow   <= 1'b0;
      o_zero     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= last_step;
      if (last_step) begin
        o_diff     <= diff_shifted;
        o_borrow   <= borrow_next;
        o_zero     <= (diff_shifted == '0);
        o_overflow <= (a_msb != b_msb) && (diff_bit != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor at WIDTH=8. A table of operand
// pairs with hand-computed results is run back to back, followed by directed
// sequences for start-while-busy, mid-operation reset and continuous start.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             i_clk;
  logic             i_reset;
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;
  logic             o_zero;
  logic             o_overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_diff     (o_diff),
    .o_borrow   (o_borrow),
    .o_zero     (o_zero),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Called one step after an edge. Requests an operation on the next edge,
  // scrambles the operand inputs afterwards, then waits (bounded) for o_done.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               output int latency, output int busyCycles);
    i_start = 1'b1;
    i_a     = a;
    i_b     = b;
    @(posedge i_clk);
    #1;
    i_start    = 1'b0;
    i_a        = ~a;
    i_b        = a ^ 8'h3C;
    latency    = 0;
    busyCycles = 0;
    while (!o_done && latency < 20) begin
      if (o_busy) busyCycles++;
      @(posedge i_clk);
      #1;
      latency++;
    end
  endtask

  initial begin
    int         latency;
    int         busyCycles;
    int         doneCount;
    int         doneAt;
    logic [7:0] capDiff;
    logic [7:0] ea;
    logic [7:0] eb;

    vecs[0] = '{a:8'h05, b:8'h03, diff:8'h02, borrow:1'b0, zero:1'b0, ovf:1'b0};
    vecs[1] = '{a:8'h03, b:8'h05, diff:8'hFE, borrow:1'b1, zero:1'b0, ovf:1'b0};
    vecs[2] = '{a:8'h80, b:8'h01, diff:8'h7F, borrow:1'b0, zero:1'b0, ovf:1'b1};
    vecs[3] = '{a:8'h5A, b:8'h5A, diff:8'h00, borrow:1'b0, zero:1'b1, ovf:1'b0};
    vecs[4] = '{a:8'h00, b:8'hFF, diff:8'h01, borrow:1'b1, zero:1'b0, ovf:1'b0};
    vecs[5] = '{a:8'h7F, b:8'hFF, diff:8'h80, borrow:1'b1, zero:1'b0, ovf:1'b1};
    vecs[6] = '{a:8'hFF, b:8'h01, diff:8'hFE, borrow:1'b0, zero:1'b0, ovf:1'b0};
    vecs[7] = '{a:8'h01, b:8'h80, diff:8'h81, borrow:1'b1, zero:1'b0, ovf:1'b1};
    vecs[8] = '{a:8'h80, b:8'h80, diff:8'h00, borrow:1'b0, zero:1'b1, ovf:1'b0};
    vecs[9] = '{a:8'hC8, b:8'h32, diff:8'h96, borrow:1'b0, zero:1'b0, ovf:1'b0};

    i_reset = 1'b1;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    checkOutput("reset_busy",  32'(o_busy),     32'd0);
    checkOutput("reset_done",  32'(o_done),     32'd0);
    checkOutput("reset_diff",  32'(o_diff),     32'd0);
    checkOutput("reset_flags", {o_borrow, o_zero, o_overflow}, 32'd0);

    // Table vectors, issued back to back in each o_done cycle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, latency, busyCycles);
      $display("[TB] vector %0d: %02h - %02h", i, vecs[i].a, vecs[i].b);
      checkOutput("latency",  32'(latency),      32'd8);
      checkOutput("busy_len", 32'(busyCycles),   32'd8);
      checkOutput("busy_end", 32'(o_busy),       32'd0);
      checkOutput("diff",     32'(o_diff),       32'(vecs[i].diff));
      checkOutput("borrow",   32'(o_borrow),     32'(vecs[i].borrow));
      checkOutput("zero",     32'(o_zero),       32'(vecs[i].zero));
      checkOutput("overflow", 32'(o_overflow),   32'(vecs[i].ovf));
    end

    // Results hold and o_done drops after the completion cycle.
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("hold_done", 32'(o_done), 32'd0);
    checkOutput("hold_diff", 32'(o_diff), 32'h96);

    // Start while busy must be ignored.
    i_start = 1'b1;
    i_a     = 8'h10;
    i_b     = 8'h01;
    @(posedge i_clk);
    #1;
    i_start   = 1'b0;
    doneCount = 0;
    doneAt    = -1;
    capDiff   = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge i_clk);
      #1;
      if (k == 2) begin
        i_start = 1'b1;
        i_a     = 8'h00;
        i_b     = 8'h01;
      end
      if (k == 3) i_start = 1'b0;
      if (o_done) begin
        doneCount++;
        doneAt  = k;
        capDiff = o_diff;
      end
    end
    checkOutput("busy_start_count", 32'(doneCount), 32'd1);
    checkOutput("busy_start_at",    32'(doneAt),    32'd8);
    checkOutput("busy_start_diff",  32'(capDiff),   32'h0F);

    // Reset in the middle of an operation, with a simultaneous start.
    i_start = 1'b1;
    i_a     = 8'h10;
    i_b     = 8'h01;
    @(posedge i_clk);
    #1;
    i_start   = 1'b0;
    doneCount = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge i_clk);
      #1;
      if (k == 3) begin
        i_reset = 1'b1;
        i_start = 1'b1;
      end
      if (k == 4) begin
        checkOutput("midreset_busy",  32'(o_busy), 32'd0);
        checkOutput("midreset_done",  32'(o_done), 32'd0);
        checkOutput("midreset_diff",  32'(o_diff), 32'd0);
        checkOutput("midreset_flags", {o_borrow, o_zero, o_overflow}, 32'd0);
        i_reset = 1'b0;
        i_start = 1'b0;
      end
      if (o_done) doneCount++;
    end
    checkOutput("midreset_no_done", 32'(doneCount), 32'd0);
    applyStimulus(8'h05, 8'h03, latency, busyCycles);
    checkOutput("post_reset_latency", 32'(latency), 32'd8);
    checkOutput("post_reset_diff",    32'(o_diff),  32'h02);

    // i_start held high with operands changing every cycle.
    for (int k = 0; k < 40; k++) begin
      i_start = 1'b1;
      i_a     = 8'(k * 37 + 11);
      i_b     = 8'(k * 91 + 5);
      @(posedge i_clk);
      #1;
      checkOutput("stream_done", 32'(o_done), 32'((k % 9) == 8));
      if ((k % 9) == 8) begin
        ea = 8'((k - 8) * 37 + 11);
        eb = 8'((k - 8) * 91 + 5);
        checkOutput("stream_diff",   32'(o_diff),   32'(8'(ea - eb)));
        checkOutput("stream_borrow", 32'(o_borrow), 32'(ea < eb));
      end
    end
    i_start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
